// File: rtl/bcd_seg_scan.sv
// Two-digit multiplexed seven-segment driver. Digits are double-buffered and the display is scanned with blank guard gaps.
// Optional macro LEADING_ZERO_BLANK_EN blanks a zero tens digit while keeping the scan timing unchanged.
module bcd_seg_scan #(
    parameter int REFRESH_DIV    = 50000,
    parameter int GUARD          = 2,
    parameter int ACTIVE_LOW_SEG = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] n2_in,
    input  logic [3:0] n1_in,
    output logic       load_ack,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       frame_done
);

    localparam int CNT_MAX = (REFRESH_DIV > GUARD) ? REFRESH_DIV : GUARD;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] SHOW_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'((GUARD > 0) ? GUARD - 1 : 0);
    localparam logic [CW-1:0] CNT_SAT   = CW'(CNT_MAX);

    typedef enum logic [2:0] {
        IDLE,
        SHOW1,
        GAP1,
        SHOW2,
        GAP2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    shadow_q, shadow_d;
    logic [7:0]    active_q, active_d;
    logic          pending_q, pending_d;
    logic          ack_q, ack_d;
    logic          frame_q, frame_d;
    logic          enter_show1;

    logic [6:0]    seg_l;
    logic [1:0]    an_l;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shadow_q  <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
            ack_q     <= 1'b0;
            frame_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            ack_q     <= ack_d;
            frame_q   <= frame_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pending_q) state_d = SHOW1;
            SHOW1:   if (cnt_q == SHOW_LAST) state_d = (GUARD > 0) ? GAP1 : SHOW2;
            GAP1:    if (cnt_q == GAP_LAST) state_d = SHOW2;
            SHOW2:   if (cnt_q == SHOW_LAST) state_d = (GUARD > 0) ? GAP2 : SHOW1;
            GAP2:    if (cnt_q == GAP_LAST) state_d = SHOW1;
            default: state_d = IDLE;
        endcase
    end

    // Every entry into SHOW1 is a frame boundary; the pre-edge shadow is what gets promoted.
    always_comb begin
        enter_show1 = (state_d == SHOW1) && (state_q != SHOW1);

        if (state_d != state_q)
            cnt_d = '0;
        else if (cnt_q == CNT_SAT)
            cnt_d = cnt_q;
        else
            cnt_d = cnt_q + CW'(1);

        shadow_d  = load ? {n2_in, n1_in} : shadow_q;
        active_d  = (enter_show1 && pending_q) ? shadow_q : active_q;
        pending_d = load ? 1'b1 : (enter_show1 ? 1'b0 : pending_q);
        ack_d     = load;
        frame_d   = enter_show1 && ((state_q == SHOW2) || (state_q == GAP2));
    end

    always_comb begin
        seg_l = '0;
        an_l  = '0;
        case (state_q)
            SHOW1: begin
                an_l  = 2'b01;
                seg_l = decode(active_q[3:0]);
            end
            SHOW2: begin
                an_l  = 2'b10;
`ifdef LEADING_ZERO_BLANK_EN
                seg_l = (active_q[7:4] == 4'd0) ? 7'h00 : decode(active_q[7:4]);
`else
                seg_l = decode(active_q[7:4]);
`endif
            end
            default: begin
                seg_l = '0;
                an_l  = '0;
            end
        endcase
    end

    assign seg        = (ACTIVE_LOW_SEG != 0) ? ~seg_l : seg_l;
    assign an         = (ACTIVE_LOW_SEG != 0) ? ~an_l : an_l;
    assign load_ack   = ack_q;
    assign frame_done = frame_q;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Table-driven check of bcd_seg_scan with REFRESH_DIV=4, GUARD=1, active-high pins.
// Each record is one clock: inputs applied before the edge, outputs expected just after it.
module tb_bcd_seg_scan;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic [3:0] n2_in = '0;
    logic [3:0] n1_in = '0;
    logic       load_ack;
    logic [6:0] seg;
    logic [1:0] an;
    logic       frame_done;

    int unsigned checks = 0;
    int unsigned passed = 0;

    bcd_seg_scan #(
        .REFRESH_DIV   (4),
        .GUARD         (1),
        .ACTIVE_LOW_SEG(0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .n2_in     (n2_in),
        .n1_in     (n1_in),
        .load_ack  (load_ack),
        .seg       (seg),
        .an        (an),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ld;
        logic [3:0] n2;
        logic [3:0] n1;
        logic [1:0] e_an;
        logic [6:0] e_seg;
        logic       e_ack;
        logic       e_fd;
    } vec_t;

    vec_t vecs[$];

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] TENS_ZERO = 7'h00;
`else
    localparam logic [6:0] TENS_ZERO = 7'h3F;
`endif

    task automatic add(input logic ld, input logic [3:0] n2, input logic [3:0] n1,
                       input logic [1:0] a, input logic [6:0] s, input logic ack, input logic fd);
        vec_t v;
        v.ld = ld; v.n2 = n2; v.n1 = n1;
        v.e_an = a; v.e_seg = s; v.e_ack = ack; v.e_fd = fd;
        vecs.push_back(v);
    endtask

    // One 10-cycle frame: 4 ones, 1 gap, 4 tens, 1 gap; optional load at cycle ld_idx.
    task automatic add_frame(input logic [6:0] ones, input logic [6:0] tens, input logic fd0,
                             input int ld_idx, input logic [3:0] n2, input logic [3:0] n1);
        for (int i = 0; i < 10; i++) begin
            logic       ld;
            logic [1:0] a;
            logic [6:0] s;
            ld = (i == ld_idx);
            if (i < 4)      begin a = 2'b01; s = ones;  end
            else if (i < 5) begin a = 2'b00; s = 7'h00; end
            else if (i < 9) begin a = 2'b10; s = tens;  end
            else            begin a = 2'b00; s = 7'h00; end
            add(ld, ld ? n2 : 4'd0, ld ? n1 : 4'd0, a, s, ld, (i == 0) ? fd0 : 1'b0);
        end
    endtask

    task automatic chk(input string name, input logic [6:0] got, input logic [6:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        add_frame(7'h00, 7'h00, 1'b0, -1, 4'd0, 4'd0);
        vecs.delete();
        for (int i = 0; i < 20; i++) add(1'b0, 4'd0, 4'd0, 2'b00, 7'h00, 1'b0, 1'b0);
        add(1'b1, 4'd1, 4'd7, 2'b00, 7'h00, 1'b1, 1'b0);
        add_frame(7'h07, 7'h06, 1'b0, -1, 4'd0, 4'd0);
        add_frame(7'h07, 7'h06, 1'b1, 6, 4'd4, 4'd2);
        add_frame(7'h5B, 7'h66, 1'b1, 2, 4'd3, 4'd3);
        add_frame(7'h4F, 7'h4F, 1'b1, 0, 4'd9, 4'd9);
        add_frame(7'h6F, 7'h6F, 1'b1, 3, 4'd12, 4'd10);
        add_frame(7'h40, 7'h40, 1'b1, 7, 4'd0, 4'd5);
        add_frame(7'h6D, TENS_ZERO, 1'b1, -1, 4'd0, 4'd0);

        step();
        chk("reset an", {5'b0, an}, 7'h00);
        chk("reset seg", seg, 7'h00);
        chk("reset ack", {6'b0, load_ack}, 7'h00);
        chk("reset fd", {6'b0, frame_done}, 7'h00);
        rst = 1'b0;

        foreach (vecs[i]) begin
            load  = vecs[i].ld;
            n2_in = vecs[i].n2;
            n1_in = vecs[i].n1;
            step();
            chk($sformatf("v%0d an", i), {5'b0, an}, {5'b0, vecs[i].e_an});
            chk($sformatf("v%0d seg", i), seg, vecs[i].e_seg);
            chk($sformatf("v%0d ack", i), {6'b0, load_ack}, {6'b0, vecs[i].e_ack});
            chk($sformatf("v%0d fd", i), {6'b0, frame_done}, {6'b0, vecs[i].e_fd});
        end
        load = 1'b0; n2_in = '0; n1_in = '0;

        // Reset mid-SHOW1 must blank the display without waiting for a clock edge.
        step();
        chk("show1 an", {5'b0, an}, 7'h01);
        chk("show1 fd", {6'b0, frame_done}, 7'h01);
        #2 rst = 1'b1;
        #1;
        chk("async an", {5'b0, an}, 7'h00);
        chk("async seg", seg, 7'h00);
        step();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("post-rst an", {5'b0, an}, 7'h00);
            chk("post-rst fd", {6'b0, frame_done}, 7'h00);
        end
        load = 1'b1; n2_in = 4'd8; n1_in = 4'd1;
        step();
        load = 1'b0;
        chk("reload ack", {6'b0, load_ack}, 7'h01);
        chk("reload an", {5'b0, an}, 7'h00);
        step();
        chk("reload ones an", {5'b0, an}, 7'h01);
        chk("reload ones seg", seg, 7'h06);
        chk("reload fd", {6'b0, frame_done}, 7'h00);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
